tnn_eval_sequencer: RTL and testbench
=====================================

// Module: tnn_eval_sequencer
// PURPOSE
//  Synthesizable on-chip evaluation engine for the combinational TNN classifier (top).
//  Streams stored test vectors from a feature ROM into the classifier and waits a settle time.
//  Compares each prediction with a gold-label ROM and accumulates correct/tested counts.
//  Sits beside the classifier in the FPGA/ASIC eval wrapper; hosts read the counts after done.
// PARAMETERS
//  FEAT_CNT       11    number of input features
//  FEAT_BITS      4     bits per feature
//  CLASS_CNT      7     number of classes; PRED_W = $clog2(CLASS_CNT)
//  TEST_CNT       1470  vectors in ROM (>=1); ADDR_W = max(1,$clog2(TEST_CNT)), CNT_W = $clog2(TEST_CNT+1)
//  SETTLE_CYCLES  4     cycles features are held before prediction is sampled (>=1)
// PORTS
//  clk            in   1                   clock, all logic on rising edge
//  rst_n          in   1                   synchronous reset, active-low
//  start          in   1                   1-cycle request to run full evaluation
//  rom_addr       out  ADDR_W              test/gold ROM address
//  rom_feat       in   FEAT_CNT*FEAT_BITS  feature word, valid 1 cycle after rom_addr
//  rom_gold       in   PRED_W              gold label, valid 1 cycle after rom_addr
//  features       out  FEAT_CNT*FEAT_BITS  registered features driven to classifier
//  prediction     in   PRED_W              classifier output (combinational from features)
//  busy           out  1                   high from cycle after accepted start until DONE
//  done           out  1                   high in DONE, held until next accepted start or reset
//  correct_cnt    out  CNT_W               vectors whose prediction == gold
//  tested_cnt     out  CNT_W               vectors checked so far
//  mism_valid     out  1                   1-cycle pulse on a mismatching check
//  mism_idx       out  ADDR_W              index of the mismatching vector (valid with mism_valid)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; rom_addr, features, counts, mism_idx = 0; busy, done, mism_valid = 0.
//  Reset mid-run aborts immediately; no partial counts survive.
//  FSM states: IDLE, FETCH, APPLY, SETTLE, CHECK, DONE.
//   IDLE/DONE: start=1 -> FETCH; idx=0, rom_addr=0, counts cleared, done=0, busy=1.
//   start while busy (FETCH..CHECK) is ignored.
//   FETCH (1 cycle): rom_addr=idx held; ROM data appears next cycle.
//   APPLY (1 cycle): features<=rom_feat, gold_q<=rom_gold; settle counter loaded with SETTLE_CYCLES-1.
//   SETTLE: stay until counter==0 (exactly SETTLE_CYCLES cycles), decrementing each cycle.
//   CHECK (1 cycle): tested_cnt+=1; prediction==gold_q -> correct_cnt+=1,
//    else mism_valid=1, mism_idx=idx. prediction>=CLASS_CNT is always a mismatch.
//    idx==TEST_CNT-1 -> DONE; else idx+=1, rom_addr=idx+1 -> FETCH.
//  Per-vector cost 3+SETTLE_CYCLES cycles; done rises TEST_CNT*(3+SETTLE_CYCLES) cycles after start edge.
//  features holds the last applied vector after DONE; counts stable in DONE.
//  Counters never wrap (CNT_W sized to TEST_CNT); idx never exceeds TEST_CNT-1.
//  correct_cnt <= tested_cnt at all times; in DONE, tested_cnt==TEST_CNT.
// TESTING
//  T1 TEST_CNT=4,S=4, model echoes gold -> done at cycle 28 after start, correct=4, tested=4, no mism_valid.
//  T2 same, model wrong on idx 2 -> correct=3, single mism_valid pulse with mism_idx=2.
//  T3 start pulsed again at cycle 10 of run -> ignored; timing and counts identical to T1.
//  T4 rst_n=0 at cycle 15 -> next cycle busy=0, counts=0, state IDLE; new start runs cleanly to correct=4.
//  T5 second start after DONE -> done drops, counts clear at once, re-run gives same totals.
//  T6 TEST_CNT=1,S=1 -> done 4 cycles after start; prediction=CLASS_CNT forced -> mismatch, correct=0.

Source files
------------

// File: rtl/tnn_eval_sequencer.sv
// rtl/tnn_eval_sequencer.sv - on-chip evaluation sequencer for the combinational TNN classifier
// Streams ROM test vectors into the classifier, waits a settle time, and scores predictions.
module tnn_eval_sequencer #(
    parameter int FEAT_CNT      = 11,
    parameter int FEAT_BITS     = 4,
    parameter int CLASS_CNT     = 7,
    parameter int TEST_CNT      = 1470,
    parameter int SETTLE_CYCLES = 4,
    localparam int PRED_W = $clog2(CLASS_CNT),
    localparam int ADDR_W = (TEST_CNT > 1) ? $clog2(TEST_CNT) : 1,
    localparam int CNT_W  = $clog2(TEST_CNT + 1),
    localparam int FEAT_W = FEAT_CNT * FEAT_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [FEAT_W-1:0] rom_feat,
    input  logic [PRED_W-1:0] rom_gold,
    output logic [FEAT_W-1:0] features,
    input  logic [PRED_W-1:0] prediction,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  correct_cnt,
    output logic [CNT_W-1:0]  tested_cnt,
    output logic              mism_valid,
    output logic [ADDR_W-1:0] mism_idx
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [31:0] CLASS_LIM = CLASS_CNT;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TEST_CNT - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        APPLY  = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [FEAT_W-1:0]  feat_q, feat_d;
    logic [PRED_W-1:0]  gold_q, gold_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic [CNT_W-1:0]   correct_q, correct_d;
    logic [CNT_W-1:0]   tested_q, tested_d;
    logic               mism_valid_q, mism_valid_d;
    logic [ADDR_W-1:0]  mism_idx_q, mism_idx_d;
    logic [31:0]        pred_ext;
    logic               pred_hit;

    // Out-of-range predictions never score, even if the gold ROM holds the same code.
    assign pred_ext = 32'(prediction);
    assign pred_hit = (prediction == gold_q) && (pred_ext < CLASS_LIM);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        feat_d       = feat_q;
        gold_d       = gold_q;
        settle_d     = settle_q;
        correct_d    = correct_q;
        tested_d     = tested_q;
        mism_valid_d = 1'b0;
        mism_idx_d   = mism_idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = FETCH;
                    idx_d     = '0;
                    correct_d = '0;
                    tested_d  = '0;
                end
            end
            FETCH: state_d = APPLY;
            APPLY: begin
                feat_d   = rom_feat;
                gold_d   = rom_gold;
                settle_d = SETTLE_LOAD;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = CHECK;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            CHECK: begin
                tested_d = tested_q + CNT_W'(1);
                if (pred_hit) begin
                    correct_d = correct_q + CNT_W'(1);
                end else begin
                    mism_valid_d = 1'b1;
                    mism_idx_d   = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            feat_q       <= '0;
            gold_q       <= '0;
            settle_q     <= '0;
            correct_q    <= '0;
            tested_q     <= '0;
            mism_valid_q <= 1'b0;
            mism_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            feat_q       <= feat_d;
            gold_q       <= gold_d;
            settle_q     <= settle_d;
            correct_q    <= correct_d;
            tested_q     <= tested_d;
            mism_valid_q <= mism_valid_d;
            mism_idx_q   <= mism_idx_d;
        end
    end

    assign rom_addr    = idx_q;
    assign features    = feat_q;
    assign correct_cnt = correct_q;
    assign tested_cnt  = tested_q;
    assign mism_valid  = mism_valid_q;
    assign mism_idx    = mism_idx_q;
    assign busy        = (state_q == FETCH) || (state_q == APPLY) ||
                         (state_q == SETTLE) || (state_q == CHECK);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_tnn_eval_sequencer.sv
// tb/tb_tnn_eval_sequencer.sv - self-checking bench for tnn_eval_sequencer
// Two instances: a 4-vector/4-settle engine and a 1-vector/1-settle engine, each with ROM and classifier models.
module tb_tnn_eval_sequencer;

    localparam int FC = 11;
    localparam int FB = 4;
    localparam int CC = 7;
    localparam int N  = 4;
    localparam int S  = 4;
    localparam int FW = FC * FB;
    localparam int PW = 3;
    localparam int AW = 2;
    localparam int CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start0, start1;
    int   errors = 0;
    int   checks = 0;

    logic [AW-1:0] addr0, mi0;
    logic [FW-1:0] rfeat0, feat0;
    logic [PW-1:0] rgold0, pred0;
    logic          busy0, done0, mv0;
    logic [CW-1:0] corr0, test0;

    logic          addr1, mi1;
    logic [FW-1:0] rfeat1, feat1;
    logic [PW-1:0] rgold1, pred1;
    logic          busy1, done1, mv1;
    logic          corr1, test1;

    logic [FW-1:0] feat_rom [N];
    logic [PW-1:0] gold_rom [N];
    logic [FW-1:0] feat_rom1;
    logic [PW-1:0] gold_rom1;
    logic          force0 = 1'b0, force1 = 1'b0;
    logic [PW-1:0] force_val0 = '0;

    int exp_correct;
    int exp_mism[$];
    int mism_seen[$];

    function automatic logic [PW-1:0] classify(input logic [FW-1:0] f);
        int s = 0;
        for (int i = 0; i < FC; i++) s += int'(f[i*FB +: FB]);
        return PW'(s % CC);
    endfunction

    always @(posedge clk) begin
        rfeat0 <= feat_rom[addr0];
        rgold0 <= gold_rom[addr0];
        rfeat1 <= feat_rom1;
        rgold1 <= gold_rom1;
    end

    assign pred0 = force0 ? force_val0 : classify(feat0);
    assign pred1 = force1 ? PW'(CC) : classify(feat1);

    tnn_eval_sequencer #(.FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(CC), .TEST_CNT(N), .SETTLE_CYCLES(S)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .rom_addr(addr0), .rom_feat(rfeat0), .rom_gold(rgold0),
        .features(feat0), .prediction(pred0), .busy(busy0), .done(done0), .correct_cnt(corr0),
        .tested_cnt(test0), .mism_valid(mv0), .mism_idx(mi0));

    tnn_eval_sequencer #(.FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(CC), .TEST_CNT(1), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .rom_addr(addr1), .rom_feat(rfeat1), .rom_gold(rgold1),
        .features(feat1), .prediction(pred1), .busy(busy1), .done(done1), .correct_cnt(corr1),
        .tested_cnt(test1), .mism_valid(mv1), .mism_idx(mi1));

    // Score the ROM contents directly from the classifier rule.
    task automatic build_expect();
        logic [PW-1:0] p;
        exp_correct = 0;
        exp_mism.delete();
        for (int i = 0; i < N; i++) begin
            p = force0 ? force_val0 : classify(feat_rom[i]);
            if (p == gold_rom[i] && int'(p) < CC) exp_correct++;
            else exp_mism.push_back(i);
        end
    endtask

    // Start edge is cycle 0; cycle n is sampled on the negedge after the n-th following edge.
    task automatic run_main(input int glitch_at, input int rst_at, output int cycles);
        bit busy_bad = 0, inv_bad = 0;
        mism_seen.delete();
        cycles = -1;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        checks++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin errors++; $display("FAIL start_state: busy=%b done=%b expected busy=1 done=0", busy0, done0); end
        checks++; if (corr0 !== 0 || test0 !== 0) begin errors++; $display("FAIL start_clear: correct=%0d tested=%0d expected 0/0", corr0, test0); end
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start0 = (n == glitch_at);
            if (mv0 === 1'b1) mism_seen.push_back(int'(mi0));
            if (corr0 > test0) inv_bad = 1;
            if (n == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                checks++; if (busy0 !== 0 || done0 !== 0 || corr0 !== 0 || test0 !== 0 || addr0 !== 0 || feat0 !== 0 || mv0 !== 0)
                    begin errors++; $display("FAIL abort_reset: busy=%b done=%b corr=%0d tested=%0d addr=%0d expected all zero", busy0, done0, corr0, test0, addr0); end
                return;
            end
            if (done0 === 1'b1) begin cycles = n; break; end
            if (busy0 !== 1'b1) busy_bad = 1;
        end
        checks++; if (cycles !== N * (3 + S)) begin errors++; $display("FAIL done_latency: got %0d expected %0d", cycles, N * (3 + S)); end
        checks++; if (busy_bad || busy0 !== 1'b0) begin errors++; $display("FAIL busy_window: busy dropped early or still %b at done, expected 0", busy0); end
        checks++; if (inv_bad) begin errors++; $display("FAIL count_invariant: correct exceeded tested, expected never"); end
    endtask

    task automatic check_results(input string tag);
        checks++; if (int'(corr0) !== exp_correct) begin errors++; $display("FAIL %s correct: got %0d expected %0d", tag, corr0, exp_correct); end
        checks++; if (int'(test0) !== N) begin errors++; $display("FAIL %s tested: got %0d expected %0d", tag, test0, N); end
        checks++; if (mism_seen.size() !== exp_mism.size()) begin errors++; $display("FAIL %s mism_count: got %0d expected %0d", tag, mism_seen.size(), exp_mism.size()); end
        else foreach (exp_mism[i]) begin
            checks++; if (mism_seen[i] !== exp_mism[i]) begin errors++; $display("FAIL %s mism_idx: got %0d expected %0d", tag, mism_seen[i], exp_mism[i]); end
        end
        checks++; if (feat0 !== feat_rom[N-1]) begin errors++; $display("FAIL %s features_hold: got %h expected %h", tag, feat0, feat_rom[N-1]); end
    endtask

    task automatic fill_rom(input int wrong_idx);
        for (int i = 0; i < N; i++) begin
            feat_rom[i] = FW'({$urandom(), $urandom()});
            gold_rom[i] = (i == wrong_idx) ? PW'((int'(classify(feat_rom[i])) + 1) % CC) : classify(feat_rom[i]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy0 !== 0 || done0 !== 0 || mv0 !== 0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b mism=%b expected 0", busy0, done0, mv0); end
        checks++; if (addr0 !== 0 || feat0 !== 0 || corr0 !== 0 || test0 !== 0 || mi0 !== 0) begin errors++; $display("FAIL reset_regs: addr=%0d corr=%0d tested=%0d expected 0", addr0, corr0, test0); end
        checks++; if (busy1 !== 0 || done1 !== 0 || test1 !== 0) begin errors++; $display("FAIL reset_dut1: busy=%b done=%b tested=%0d expected 0", busy1, done1, test1); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_correct();
        int c;
        fill_rom(-1); build_expect();
        run_main(0, 0, c);
        check_results("all_correct");
        repeat (3) @(negedge clk);
        checks++; if (done0 !== 1'b1 || int'(corr0) !== exp_correct) begin errors++; $display("FAIL done_hold: done=%b corr=%0d expected 1/%0d", done0, corr0, exp_correct); end
    endtask

    task automatic test_one_wrong();
        int c;
        fill_rom(2); build_expect();
        run_main(0, 0, c);
        check_results("one_wrong");
    endtask

    task automatic test_start_while_busy();
        int c;
        fill_rom(-1); build_expect();
        run_main(10, 0, c);
        check_results("start_busy");
    endtask

    task automatic test_abort_reset();
        int c;
        fill_rom(-1); build_expect();
        run_main(0, 15, c);
        run_main(0, 0, c);
        check_results("after_abort");
    endtask

    task automatic test_back_to_back();
        int c;
        fill_rom(1); build_expect();
        run_main(0, 0, c);
        check_results("b2b_first");
        run_main(0, 0, c);
        check_results("b2b_second");
    endtask

    task automatic test_random();
        int c;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N; i++) begin
                feat_rom[i] = FW'({$urandom(), $urandom()});
                gold_rom[i] = ($urandom_range(0, 1) == 1) ? classify(feat_rom[i]) : PW'($urandom_range(0, 7));
            end
            force0 = (it == 5);
            force_val0 = PW'($urandom_range(0, 7));
            build_expect();
            run_main(0, 0, c);
            check_results("random");
        end
        force0 = 1'b0;
    endtask

    task automatic test_single(input logic frc, input int exp_corr);
        int n = -1;
        bit saw_mism = 0;
        feat_rom1 = FW'({$urandom(), $urandom()});
        force1 = frc;
        gold_rom1 = frc ? PW'(CC) : classify(feat_rom1);
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (mv1 === 1'b1 && mi1 === 1'b0) saw_mism = 1;
            if (done1 === 1'b1) begin n = k; break; end
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL single_latency: got %0d expected 4", n); end
        checks++; if (int'(corr1) !== exp_corr || test1 !== 1'b1) begin errors++; $display("FAIL single_counts: corr=%0d tested=%0d expected %0d/1", corr1, test1, exp_corr); end
        checks++; if (saw_mism !== (exp_corr == 0)) begin errors++; $display("FAIL single_mism: saw=%b expected %b", saw_mism, exp_corr == 0); end
        checks++; if (feat1 !== feat_rom1 || addr1 !== 1'b0) begin errors++; $display("FAIL single_hold: feat=%h addr=%b expected %h/0", feat1, addr1, feat_rom1); end
    endtask

    initial begin
        test_reset();
        test_all_correct();
        test_one_wrong();
        test_start_while_busy();
        test_abort_reset();
        test_back_to_back();
        test_random();
        test_single(1'b1, 0);
        test_single(1'b0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
